// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register: a main register drives the outputs and a skid register
// absorbs one entry under downstream stall so in_ready never depends on out_ready.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 21,
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic              accept;
  logic              main_load;

  assign accept    = in_valid & in_ready_q;
  assign main_load = ~main_valid_q | out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      skid_data_d  = '0;
    end else if (main_load) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        // A same-cycle accept queues behind the entry leaving the skid.
        if (accept) begin
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
    end
  end

  // in_ready is its own flop so it carries no path from out_ready.
  assign in_ready_d = ~skid_valid_d;

  always_comb begin
    bubble_d = bubble_q;
    if (cnt_clr) begin
      bubble_d = '0;
    end else if (!main_valid_q && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
      bubble_q     <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
      bubble_q     <= bubble_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = main_valid_q;
  assign out_ctrl     = main_ctrl_q;
  assign out_data     = main_data_q;
  assign bubble_count = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted entries are queued and matched against
// downstream transfers; directed checks cover stall, flush, bubbles and async reset.
module tb_pipe_stage_reg;

  localparam int unsigned CtrlW = 21;
  localparam int unsigned DataW = 160;
  localparam int unsigned CntW  = 16;

  typedef logic [CtrlW+DataW-1:0] entry_t;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [CtrlW-1:0] in_ctrl;
  logic [DataW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CtrlW-1:0] out_ctrl;
  logic [DataW-1:0] out_data;
  logic             cnt_clr;
  logic [CntW-1:0]  bubble_count;

  logic             sat_clr;
  logic             sat_in_ready;
  logic             sat_out_valid;
  logic [3:0]       sat_out_ctrl;
  logic [7:0]       sat_out_data;
  logic [2:0]       sat_count;

  int n_cmp = 0;
  int n_err = 0;
  entry_t sb_q[$];

  pipe_stage_reg #(.CTRL_W(CtrlW), .DATA_W(DataW), .CNT_W(CntW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .cnt_clr(cnt_clr), .bubble_count(bubble_count)
  );

  // Idle instance with a narrow counter to exercise saturation.
  pipe_stage_reg #(.CTRL_W(4), .DATA_W(8), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(1'b0), .in_ready(sat_in_ready),
    .in_ctrl(4'h0), .in_data(8'h00), .out_valid(sat_out_valid), .out_ready(1'b1),
    .out_ctrl(sat_out_ctrl), .out_data(sat_out_data), .cnt_clr(sat_clr),
    .bubble_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DataW-1:0] mk_data(input int v);
    return {32'hC0DE_0000 + 32'(v), 96'(v * 3), 32'(v)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int v);
    in_valid = 1'b1;
    in_ctrl  = CtrlW'(v);
    in_data  = mk_data(v);
  endtask

  // Inputs are stable between posedge+1 and the next posedge, so the negedge sees what
  // the next edge will act on.
  always @(negedge clk) begin
    if (reset || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_out", {out_ctrl, out_data}, 256'h0);
        end else begin
          check_eq("sb_out", {out_ctrl, out_data}, sb_q.pop_front());
        end
      end
      if (in_valid && in_ready) sb_q.push_back({in_ctrl, in_data});
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; cnt_clr = 1'b0; sat_clr = 1'b0;
    step();
    step();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_ctrl", out_ctrl, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_bubble", bubble_count, 0);
    reset = 1'b0;

    // Idle bubbles, then clear
    repeat (5) step();
    check_eq("bubble_5", bubble_count, 5);
    check_eq("sat_5", sat_count, 5);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check_eq("bubble_clr", bubble_count, 0);

    // Back-to-back stream with one-cycle latency
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(i);
      step();
      check_eq("stream_valid", out_valid, 1);
      check_eq("stream_data", out_data, mk_data(i));
    end
    in_valid = 1'b0;
    check_eq("stream_bubble", bubble_count, 1);
    check_eq("sat_sat", sat_count, 7);
    step();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check_eq("sat_clr", sat_count, 0);

    // Stall: A in main, B in skid, C held upstream
    out_ready = 1'b0;
    offer(10);
    step();
    offer(11);
    step();
    check_eq("stall_in_ready", in_ready, 0);
    check_eq("stall_hold_a", out_data, mk_data(10));
    offer(12);
    step();
    check_eq("stall_stable", out_data, mk_data(10));
    check_eq("stall_ctrl", out_ctrl, 10);
    check_eq("stall_in_ready2", in_ready, 0);
    out_ready = 1'b1;
    step();
    check_eq("stall_b", out_data, mk_data(11));
    check_eq("stall_ready_back", in_ready, 1);
    step();
    in_valid = 1'b0;
    check_eq("stall_c", out_data, mk_data(12));
    step();
    check_eq("stall_drain", sb_q.size(), 0);

    // Flush under stall with main and skid full
    out_ready = 1'b0;
    offer(20);
    step();
    offer(21);
    step();
    flush = 1'b1;
    offer(23);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_ctrl", out_ctrl, 0);
    check_eq("flush_data", out_data, 0);
    check_eq("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("flush_no_reappear", out_valid, 0);
    end

    // Flush drops an entry offered while in_ready is high
    out_ready = 1'b0;
    offer(30);
    step();
    flush = 1'b1;
    offer(31);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("flush2_valid", out_valid, 0);
    check_eq("flush2_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    check_eq("flush2_dropped", out_valid, 0);

    // Asynchronous reset between edges with both entries full
    out_ready = 1'b0;
    offer(40);
    step();
    offer(41);
    step();
    in_valid = 1'b0;
    check_eq("areset_full", in_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("areset_valid", out_valid, 0);
    check_eq("areset_data", out_data, 0);
    check_eq("areset_in_ready", in_ready, 1);
    check_eq("areset_bubble", bubble_count, 0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    offer(50);
    step();
    in_valid = 1'b0;
    check_eq("post_rst_valid", out_valid, 1);
    check_eq("post_rst_data", out_data, mk_data(50));
    step();
    check_eq("final_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 21: width of control field; zeroed on reset and flush.
REQ-002 Parameter DATA_W, default 160: width of datapath field; zeroed on reset and flush.
REQ-003 Parameter CNT_W, default 16: width of bubble counter.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous kill of all held entries (branch/jump redirect).
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 in_ctrl  input  CTRL_W  upstream control bits.
REQ-010 in_data  input  DATA_W  upstream data (pc, pc+4, operands, immediate).
REQ-011 out_valid  output  1  main register holds a live entry.
REQ-012 out_ready  input  1  downstream accepts; deasserted for stall (busywait).
REQ-013 out_ctrl  output  CTRL_W  registered control bits.
REQ-014 out_data  output  DATA_W  registered data.
REQ-015 cnt_clr  input  1  synchronous clear of bubble_count.
REQ-016 bubble_count  output  CNT_W  cycles with out_valid low since reset/clear.

Function
REQ-017 Storage SHALL be two entries: main register (drives out_*) and one skid register; each with own valid bit.
REQ-018 in_ready SHALL equal NOT skid_valid, driven directly from a flop (no combinational path from out_ready).
REQ-019 Accept SHALL occur when in_valid AND in_ready; downstream transfer SHALL occur when out_valid AND out_ready.
REQ-020 Main SHALL load when out_valid is low or out_ready is high: from skid if skid_valid, else from input if accepted, else out_valid goes low.
REQ-021 When main loads from skid and an input is accepted the same cycle, input SHALL go to main-after-skid ordering, i.e. into skid; order SHALL always be preserved.
REQ-022 When main is held (out_valid high, out_ready low) and an input is accepted, input SHALL go to skid.
REQ-023 Latency SHALL be one cycle input-to-output when unstalled; throughput one entry per cycle with out_ready held high.
REQ-024 Held entries SHALL keep out_ctrl/out_data stable while out_valid high and out_ready low.
REQ-025 flush SHALL override all other activity: next cycle out_valid=0, skid_valid=0, out_ctrl=0, out_data=0; input offered in the flush cycle SHALL be dropped.
REQ-026 flush with out_ready low SHALL still clear (flush beats stall).
REQ-027 bubble_count SHALL increment on every clock where out_valid is low, saturating at 2^CNT_W-1; cnt_clr SHALL set it to 0 and has priority over increment.
REQ-028 A dropped or transferred entry SHALL never reappear; no entry is duplicated.

Reset
REQ-029 While reset high: out_valid=0, skid_valid=0, in_ready=1 after reset release computation, out_ctrl=0, out_data=0, bubble_count=0.
REQ-030 Reset SHALL act asynchronously on assertion mid-operation, discarding both entries; first accept allowed on first clock edge after deassertion.

Verification
REQ-031 Stream: out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later, out_valid continuous, bubble_count unchanged.
REQ-032 Stall: entry A in main, out_ready=0, offer B -> B in skid, in_ready=0 next cycle, C held upstream; release out_ready -> output A, B, C in order, no loss.
REQ-033 Flush under stall: main=A, skid=B, out_ready=0, flush=1 with in_valid=1 D -> next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1, D never appears.
REQ-034 Bubbles: reset release, idle 5 cycles -> bubble_count=5; cnt_clr one cycle -> 0; with CNT_W=3, idle 10 cycles -> saturates at 7.
REQ-035 Async reset mid-stall: main and skid full, assert reset between clock edges -> out_valid=0 and out_data=0 immediately, before next edge.
